// File: rtl/key_led_ctrl_if.sv
// Key/LED controller signal bundle.
// master: board side (drives keys), slave: controller side (drives LEDs).
// With KEY_LED_CTRL_PWM_EN defined, the bundle also carries led_duty.
interface key_led_ctrl_if #(
  parameter int unsigned NUM_KEYS = 2,
  parameter int unsigned NUM_LEDS = 4
);
  logic [NUM_KEYS-1:0] key;
  logic [NUM_LEDS-1:0] usr_led;
  logic [2:0]          led_mode;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_long;
  logic                tick;
`ifdef KEY_LED_CTRL_PWM_EN
  logic [3:0]          led_duty;

  modport master (
    output key, output led_duty,
    input  usr_led, input led_mode, input key_press, input key_long, input tick
  );
  modport slave (
    input  key, input led_duty,
    output usr_led, output led_mode, output key_press, output key_long, output tick
  );
`else
  modport master (
    output key,
    input  usr_led, input led_mode, input key_press, input key_long, input tick
  );
  modport slave (
    input  key,
    output usr_led, output led_mode, output key_press, output key_long, output tick
  );
`endif
endinterface

// File: rtl/key_led_ctrl.sv
// Key debounce and LED pattern controller.
// Debounces every key on both edges, emits press / long-press pulses, steers a
// five-mode LED pattern FSM with key[0]/key[1] and steps the pattern on a tick.
// Optional macro KEY_LED_CTRL_PWM_EN adds led_duty dimming via a 4-bit PWM.
module key_led_ctrl #(
  parameter int unsigned NUM_KEYS         = 2,
  parameter int unsigned NUM_LEDS         = 4,
  parameter int unsigned DEBOUNCE_CYCLES  = 8192,
  parameter int unsigned TICK_CYCLES      = 12500000,
  parameter int unsigned LONG_PRESS_TICKS = 8
) (
  input logic           clk_50m,
  input logic           rst_n,
  key_led_ctrl_if.slave bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TK_W = $clog2(TICK_CYCLES);
  localparam int unsigned LP_W = $clog2(LONG_PRESS_TICKS + 1);
  localparam logic [NUM_LEDS-1:0] LED_LSB = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LED_MSB = LED_LSB << (NUM_LEDS - 1);

  typedef enum logic [2:0] {
    MODE_BLINK  = 3'd0,
    MODE_WALK_L = 3'd1,
    MODE_WALK_R = 3'd2,
    MODE_COUNT  = 3'd3,
    MODE_BOUNCE = 3'd4
  } mode_e;

  logic [NUM_KEYS-1:0]           sync1, sync2;
  logic [NUM_KEYS-1:0][DB_W-1:0] db_cnt;
  logic [NUM_KEYS-1:0]           deb, deb_d;
  logic [NUM_KEYS-1:0]           press_q, long_q;
  logic [NUM_KEYS-1:0][LP_W-1:0] hold_cnt;
  logic [TK_W-1:0]               tick_cnt;
  logic                          tick_q;
  mode_e                         mode_q, mode_nxt;
  logic [NUM_LEDS-1:0]           pattern, pat_step, led_q;
  logic                          dir_up, dir_step;

  function automatic logic [NUM_LEDS-1:0] reload_pat(input mode_e m);
    case (m)
      MODE_WALK_L, MODE_BOUNCE: reload_pat = LED_LSB;
      MODE_WALK_R:              reload_pat = LED_MSB;
      default:                  reload_pat = '0;
    endcase
  endfunction

  // Two-stage synchroniser, debounce counters and rising-edge press pulse.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      db_cnt  <= '0;
      deb     <= '0;
      deb_d   <= '0;
      press_q <= '0;
    end else begin
      sync1   <= bus.key;
      sync2   <= sync1;
      deb_d   <= deb;
      press_q <= deb & ~deb_d;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          deb[i]    <= ~deb[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Free-running pattern-step tick, one pulse per TICK_CYCLES.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else if (tick_cnt == TK_W'(TICK_CYCLES - 1)) begin
      tick_cnt <= '0;
      tick_q   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick_q   <= 1'b0;
    end
  end

  // Per-key hold counters in ticks; saturation makes the long pulse one-shot.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      long_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (!deb[i]) begin
          hold_cnt[i] <= '0;
          long_q[i]   <= 1'b0;
        end else if (tick_q && hold_cnt[i] != LP_W'(LONG_PRESS_TICKS)) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
          long_q[i]   <= (hold_cnt[i] == LP_W'(LONG_PRESS_TICKS - 1));
        end else begin
          long_q[i]   <= 1'b0;
        end
      end
    end
  end

  // Next mode from the key pulses; long press on key 0 overrides presses.
  always_comb begin
    mode_nxt = mode_q;
    if (long_q[0]) begin
      mode_nxt = MODE_BLINK;
    end else if (press_q[0] && !press_q[1]) begin
      mode_nxt = (mode_q == MODE_BOUNCE) ? MODE_BLINK : mode_e'(mode_q + 3'd1);
    end else if (press_q[1] && !press_q[0]) begin
      mode_nxt = (mode_q == MODE_BLINK) ? MODE_BOUNCE : mode_e'(mode_q - 3'd1);
    end
  end

  // One tick step of the current pattern. BOUNCE turns around on the end bit
  // so that bit is lit for a single step.
  always_comb begin
    pat_step = pattern;
    dir_step = dir_up;
    case (mode_q)
      MODE_BLINK:  pat_step = ~pattern;
      MODE_WALK_L: pat_step = (pattern << 1) | (pattern >> (NUM_LEDS - 1));
      MODE_WALK_R: pat_step = (pattern >> 1) | (pattern << (NUM_LEDS - 1));
      MODE_COUNT:  pat_step = pattern + 1'b1;
      MODE_BOUNCE: begin
        if (NUM_LEDS > 1) begin
          if (dir_up) begin
            if (pattern[NUM_LEDS-1]) begin
              pat_step = pattern >> 1;
              dir_step = 1'b0;
            end else begin
              pat_step = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              pat_step = pattern << 1;
              dir_step = 1'b1;
            end else begin
              pat_step = pattern >> 1;
            end
          end
        end
      end
      default: pat_step = pattern;
    endcase
  end

  // Mode FSM and pattern register; a reload on mode change swallows a coincident tick.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_BLINK;
      pattern <= '0;
      dir_up  <= 1'b0;
    end else begin
      mode_q <= mode_nxt;
      if (mode_nxt != mode_q) begin
        pattern <= reload_pat(mode_nxt);
        dir_up  <= 1'b1;
      end else if (tick_q) begin
        pattern <= pat_step;
        dir_up  <= dir_step;
      end
    end
  end

`ifdef KEY_LED_CTRL_PWM_EN
  logic [3:0] pwm_cnt;

  // LED output stage gated by the free-running PWM against led_duty.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led_q   <= pattern & {NUM_LEDS{pwm_cnt < bus.led_duty}};
    end
  end
`else
  // LED output stage: registered copy of the pattern.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= pattern;
    end
  end
`endif

  assign bus.usr_led   = led_q;
  assign bus.led_mode  = mode_q;
  assign bus.key_press = press_q;
  assign bus.key_long  = long_q;
  assign bus.tick      = tick_q;

endmodule

// File: doc/key_led_ctrl.md
Name: key_led_ctrl

Overview:
Parametrised key-debounce and LED pattern controller. It is the next generation of the board's user-LED logic and serves any number of keys and LEDs. Keys are debounced on both edges and produce short-press and long-press pulses. A mode FSM driven by the keys selects one of five LED patterns, which advance on a programmable tick. It sits next to the top-level glue on clk_50m and drives the usr_led pins directly.

Parameters:
NUM_KEYS, 2, number of raw key inputs; must be >= 2; key[0] and key[1] steer the mode.
NUM_LEDS, 4, number of LED outputs; must be >= 1.
DEBOUNCE_CYCLES, 8192, consecutive stable samples required to accept a key level change; must be >= 2.
TICK_CYCLES, 12500000, clk_50m cycles per pattern step (0.25 s at 50 MHz); must be >= 2.
LONG_PRESS_TICKS, 8, ticks a key must be held to count as a long press; must be >= 1.

Ports:
clk_50m  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
key  in  NUM_KEYS  raw asynchronous keys, high = pressed
usr_led  out  NUM_LEDS  registered LED drive, high = lit
led_mode  out  3  current mode: 0 BLINK, 1 WALK_L, 2 WALK_R, 3 COUNT, 4 BOUNCE
key_press  out  NUM_KEYS  one-cycle pulse when a debounced key rises
key_long  out  NUM_KEYS  one-cycle pulse when a press reaches the long-press time
tick  out  1  one-cycle pulse per pattern step

Behaviour:
- Reset: rst_n is asynchronous and active-low with a single clock. While rst_n=0 all registers clear: synchronisers, debounce counters, debounced states, tick counter, hold counters, pattern, mode, and all outputs (usr_led, led_mode, key_press, key_long, tick = 0).
- Synchroniser: 2-FF per key; reset value 0.
- Debounce, per key, counter width $clog2(DEBOUNCE_CYCLES+1):
  - When the synchronised sample differs from the debounced state, the counter increments.
  - When the sample equals the debounced state, the counter clears.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never flip the state. Both press and release edges are debounced.
- key_press[i]: registered; asserted for exactly one cycle, one edge after debounced[i] goes 0->1. For a clean raw rise first sampled at edge 1, key_press is high after edge DEBOUNCE_CYCLES+3.
- Tick generator: counter runs 0..TICK_CYCLES-1 and wraps. tick is registered high for one cycle per wrap; period is exactly TICK_CYCLES.
- Long press, per key:
  - The hold counter clears while debounced[i]=0.
  - While held, it increments on each tick and saturates at LONG_PRESS_TICKS.
  - key_long[i] pulses once, on the tick where the count becomes LONG_PRESS_TICKS.
  - Release and re-press re-arms it.
- Mode FSM, evaluated on key_press / key_long, which are already one-cycle pulses:
  - key_press[0] alone: next mode, 4 wraps to 0.
  - key_press[1] alone: previous mode, 0 wraps to 4.
  - key_press[0] and key_press[1] in the same cycle: no change.
  - key_long[0]: force mode 0. It takes precedence over any key_press in the same cycle.
  - Keys with index >= 2 only drive key_press and key_long; they have no mode effect.
  - led_mode updates one edge after the pulse.
- Pattern register, NUM_LEDS bits:
  - On any mode change it reloads: BLINK=0, WALK_L=bit0, WALK_R=MSB, COUNT=0, BOUNCE=bit0 with direction up.
  - A reload in the same cycle as a tick wins; that tick is dropped.
  - Otherwise, on tick:
    - BLINK: invert all bits.
    - WALK_L: rotate toward MSB; MSB wraps to bit0.
    - WALK_R: rotate toward bit0; bit0 wraps to MSB.
    - COUNT: add 1 modulo 2^NUM_LEDS, so all-ones goes to 0.
    - BOUNCE: move one position. The direction reverses when the lit bit reaches MSB or bit0, so the end bit is lit for one step only. With NUM_LEDS=1, bit0 stays lit.
  - When a mode write leaves the mode unchanged (the simultaneous-press case), there is no reload.
- usr_led: registered copy of the pattern; one cycle latency from the pattern.

Optional Feature:
Macro KEY_LED_CTRL_PWM_EN.
- Defined:
  - Adds input port led_duty, 4 bits.
  - Adds a free-running 4-bit PWM counter, reset to 0.
  - usr_led = pattern & {NUM_LEDS{pwm_cnt < led_duty}}. led_duty=0 means always off; 15 gives 15/16 on-time.
- Undefined: no led_duty port and no PWM counter; usr_led = pattern.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, TICK_CYCLES=10, LONG_PRESS_TICKS=3, NUM_LEDS=4.
- Reset: assert rst_n=0 mid-run with mode 3 and pattern 0101 -> all outputs 0 immediately (asynchronous); after release, led_mode=0 and the first tick appears 10 cycles later.
- Glitch reject: key[0] high for 3 cycles, low, repeated 5 times -> key_press=0 and led_mode stays 0. Then key[0] high, held -> key_press[0] pulses once, after edge 7 from the first sample; led_mode=1 one edge later.
- Walk and wrap: in mode 1, over 5 ticks -> usr_led 0001, 0010, 0100, 1000, 0001. key_press[1] in mode 0 -> led_mode=4.
- Count and bounce: mode 3 from reload, 16 ticks -> usr_led 0000..1111, then 0000. Mode 4, 7 ticks -> 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Simultaneous events: key[0] and key[1] rise on the same cycle -> two key_press pulses, led_mode unchanged. Mode change coinciding with tick -> pattern equals the reload value.
- Long press: hold key[0] in mode 2 for 3 ticks -> a single key_long[0] pulse, led_mode=0. Hold for 10 more ticks -> no further pulse.
- (Only with KEY_LED_CTRL_PWM_EN defined) led_duty=4 -> each lit LED is high exactly 4 of every 16 cycles.
